// File: rtl/imem_program_loader.sv
// Instruction-memory loader: clears all words, streams a program in from START_WORD,
// then releases the CPU from reset and steers the fetch address onto the read port.
module imem_program_loader #(
   parameter int DEPTH      = 128,
   parameter int ADDR_W     = 7,
   parameter int START_WORD = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [31:0]       load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_done,
   output logic              load_error,
   output logic [ADDR_W:0]   load_count,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       fetch_addr,
   output logic [ADDR_W-1:0] mem_raddr,
   output logic              fetch_oob,
   output logic              cpu_rst_n
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_RUN,
      S_ERROR
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] START_ADDR = ADDR_W'(START_WORD);

   state_t            state;
   logic [ADDR_W-1:0] clr_ptr;
   logic [ADDR_W-1:0] wptr;
   logic              accept;
   logic              restart;

   assign load_ready = (state == S_LOAD);
   assign accept     = load_valid && (state == S_LOAD);

   // A beat accepted in the same cycle as load_start takes priority over the abort.
   always_comb begin
      restart = 1'b0;
      case (state)
         S_IDLE, S_RUN, S_ERROR: restart = load_start;
         S_LOAD:                 restart = load_start && !load_valid;
         default:                restart = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         clr_ptr    <= '0;
         wptr       <= '0;
         load_done  <= 1'b0;
         load_error <= 1'b0;
         load_count <= '0;
         mem_we     <= 1'b0;
         mem_waddr  <= '0;
         mem_wdata  <= '0;
         cpu_rst_n  <= 1'b0;
      end else begin
         mem_we    <= 1'b0;
         load_done <= 1'b0;
         // Rises one edge after RUN entry so the last program word lands first.
         cpu_rst_n <= (state == S_RUN);

         case (state)
            S_CLEAR: begin
               mem_we    <= 1'b1;
               mem_waddr <= clr_ptr;
               mem_wdata <= '0;
               clr_ptr   <= clr_ptr + 1'b1;
               if (clr_ptr == LAST_ADDR) begin
                  state <= S_LOAD;
                  wptr  <= START_ADDR;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  mem_we     <= 1'b1;
                  mem_waddr  <= wptr;
                  mem_wdata  <= load_data;
                  wptr       <= wptr + 1'b1;
                  load_count <= load_count + 1'b1;
                  if (load_last) begin
                     state     <= S_RUN;
                     load_done <= 1'b1;
                  end else if (wptr == LAST_ADDR) begin
                     state      <= S_ERROR;
                     load_error <= 1'b1;
                  end
               end
            end
            S_IDLE, S_RUN, S_ERROR: begin
            end
            default: state <= S_IDLE;
         endcase

         if (restart) begin
            state      <= S_CLEAR;
            clr_ptr    <= '0;
            load_count <= '0;
            load_error <= 1'b0;
            cpu_rst_n  <= 1'b0;
         end
      end
   end

   assign mem_raddr = (state == S_RUN) ? fetch_addr[ADDR_W+1:2] : '0;
   assign fetch_oob = (state == S_RUN) && (|fetch_addr[31:ADDR_W+2]);

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: memory writes are checked against a scoreboard queue,
// read-mux behaviour against a vector table, plus hand sequences for load/abort/overflow/reset.
module tb_imem_program_loader;

   typedef struct {
      logic [6:0]  addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [31:0] fa;
      logic [6:0]  raddr;
      logic        oob;
   } rd_vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_start, load_valid, load_last;
   logic [31:0] load_data;
   logic        load_ready, load_done, load_error;
   logic [7:0]  load_count;
   logic        mem_we;
   logic [6:0]  mem_waddr;
   logic [31:0] mem_wdata;
   logic [31:0] fetch_addr;
   logic [6:0]  mem_raddr;
   logic        fetch_oob, cpu_rst_n;

   int   total = 0;
   int   bad   = 0;
   wr_t  sb[$];
   logic [6:0] wexp;
   rd_vec_t vecs [6];

   imem_program_loader dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
      .load_last(load_last), .load_ready(load_ready), .load_done(load_done),
      .load_error(load_error), .load_count(load_count),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
      .fetch_addr(fetch_addr), .mem_raddr(mem_raddr), .fetch_oob(fetch_oob),
      .cpu_rst_n(cpu_rst_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every observed write must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write actual=%0h:%0h required=none at %0t",
                     mem_waddr, mem_wdata, $time);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("mem_write", {25'd0, mem_waddr, mem_wdata}, {25'd0, e.addr, e.data});
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [31:0] data, input logic last, input logic valid);
      load_valid = valid;
      load_data  = data;
      load_last  = last;
      if (valid) begin
         sb.push_back('{addr: wexp, data: data});
         wexp = wexp + 7'd1;
      end
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic do_clear;
      load_start = 1'b1;
      for (int i = 0; i < 128; i++) sb.push_back('{addr: 7'(i), data: 32'd0});
      tick();
      load_start = 1'b0;
      check("clear_count_reset", 64'(load_count), 64'd0);
      check("clear_cpu_rst", 64'(cpu_rst_n), 64'd0);
      repeat (127) tick();
      check("clear_busy_ready", 64'(load_ready), 64'd0);
      tick();
      check("clear_done_ready", 64'(load_ready), 64'd1);
      check("clear_pending", 64'(sb.size()), 64'd1);
      wexp = 7'd1;
   endtask

   initial begin
      vecs[0] = '{fa: 32'h0000_0014, raddr: 7'd5,   oob: 1'b0};
      vecs[1] = '{fa: 32'h0000_0000, raddr: 7'd0,   oob: 1'b0};
      vecs[2] = '{fa: 32'h0000_01FC, raddr: 7'd127, oob: 1'b0};
      vecs[3] = '{fa: 32'h0000_0017, raddr: 7'd5,   oob: 1'b0};
      vecs[4] = '{fa: 32'h0000_0200, raddr: 7'd0,   oob: 1'b1};
      vecs[5] = '{fa: 32'h8000_0004, raddr: 7'd1,   oob: 1'b1};

      rst_n = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
      load_data = 32'd0; fetch_addr = 32'd0; wexp = 7'd1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
      check("rst_load_count", 64'(load_count), 64'd0);
      check("rst_load_error", 64'(load_error), 64'd0);
      check("rst_load_ready", 64'(load_ready), 64'd0);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_load_done", 64'(load_done), 64'd0);
      rst_n = 1'b1;
      tick();
      check("idle_ready", 64'(load_ready), 64'd0);

      // Clear then a 9-word program, last on the 9th beat.
      do_clear();
      for (int i = 0; i < 9; i++) beat(32'h1000_0063 + 32'(i), (i == 8), 1'b1);
      check("load_done_pulse", 64'(load_done), 64'd1);
      check("run_cpu_held", 64'(cpu_rst_n), 64'd0);
      check("load_count_9", 64'(load_count), 64'd9);
      check("run_ready", 64'(load_ready), 64'd0);
      tick();
      check("load_done_end", 64'(load_done), 64'd0);
      check("cpu_release", 64'(cpu_rst_n), 64'd1);

      for (int i = 0; i < 6; i++) begin
         fetch_addr = vecs[i].fa;
         tick();
         check($sformatf("run_raddr_%0d", i), 64'(mem_raddr), 64'(vecs[i].raddr));
         check($sformatf("run_oob_%0d", i), 64'(fetch_oob), 64'(vecs[i].oob));
      end

      // Restart from RUN, then the same fetch vectors are masked while loading.
      do_clear();
      for (int i = 0; i < 6; i++) begin
         fetch_addr = vecs[i].fa;
         tick();
         check($sformatf("load_raddr_%0d", i), 64'(mem_raddr), 64'd0);
         check($sformatf("load_oob_%0d", i), 64'(fetch_oob), 64'd0);
      end

      for (int i = 0; i < 8; i++) beat(32'hA000_0000 + 32'(i), 1'b0, (i % 2 == 0));
      check("toggle_count", 64'(load_count), 64'd4);

      load_start = 1'b1;
      beat(32'hBEEF_0005, 1'b0, 1'b1);
      load_start = 1'b0;
      check("beat_wins_ready", 64'(load_ready), 64'd1);
      check("beat_wins_count", 64'(load_count), 64'd5);

      do_clear();  // abort from LOAD

      // Overflow: 127 beats fill words 1..127 without load_last.
      for (int i = 0; i < 127; i++) beat(32'hC000_0000 + 32'(i), 1'b0, 1'b1);
      check("ovf_error", 64'(load_error), 64'd1);
      check("ovf_count", 64'(load_count), 64'd127);
      check("ovf_ready", 64'(load_ready), 64'd0);
      check("ovf_cpu", 64'(cpu_rst_n), 64'd0);
      load_valid = 1'b1; load_data = 32'hDEAD_DEAD;
      tick();
      load_valid = 1'b0;
      check("ovf_error_sticky", 64'(load_error), 64'd1);
      check("ovf_cpu_held", 64'(cpu_rst_n), 64'd0);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      check("err_cleared", 64'(load_error), 64'd0);
      for (int i = 0; i < 127; i++) sb.push_back('{addr: 7'(i + 1), data: 32'd0});
      sb.push_front('{addr: 7'd0, data: 32'd0});
      repeat (128) tick();
      check("reload_ready", 64'(load_ready), 64'd1);
      wexp = 7'd1;

      // Async reset mid-LOAD right after the 3rd beat is issued.
      beat(32'h0000_0001, 1'b0, 1'b1);
      beat(32'h0000_0002, 1'b0, 1'b1);
      beat(32'h0000_0003, 1'b0, 1'b1);
      check("pre_reset_count", 64'(load_count), 64'd3);
      load_valid = 1'b1; load_data = 32'h5555_5555;
      #1 rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      check("arst_mem_we", 64'(mem_we), 64'd0);
      check("arst_ready", 64'(load_ready), 64'd0);
      check("arst_count", 64'(load_count), 64'd0);
      check("arst_cpu", 64'(cpu_rst_n), 64'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
      load_valid = 1'b0;
      check("post_rst_idle_ready", 64'(load_ready), 64'd0);
      check("post_rst_cpu", 64'(cpu_rst_n), 64'd0);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
